// File: rtl/inst_fetch.sv
// Instruction fetch stage: a single outstanding memory request, flushed on redirect.
// Hands the fetched word and its PC downstream over a valid/ready handshake.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] pc_in,
  output logic [31:0] npc,
  output logic        pc_ena,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_any;

  assign kill_any = kill_q | redirect;

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    valid_d  = valid_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      IDLE: begin
        if (ena) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          state_d  = WAIT;
          req_pc_d = pc_in;
          kill_d   = redirect;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_any) begin
            kill_d  = 1'b0;
            state_d = ena ? REQ : IDLE;
          end else begin
            inst_d  = imem_rdata;
            ipc_d   = req_pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else begin
          kill_d = kill_any;
        end
      end
      HOLD: begin
        // a redirect wins over a same-cycle accept
        if (redirect) begin
          valid_d = 1'b0;
          state_d = REQ;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          state_d = ena ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req   = rst & (state_q == REQ);
  assign imem_addr  = pc_in;
  assign pc_ena     = rst & (redirect | (imem_req & imem_gnt));
  assign npc        = redirect ? (redirect_pc & ~32'h3)
                               : (pc_in + 32'd4);
  assign inst_valid = valid_q;
  assign inst_out   = inst_q;
  assign inst_pc    = ipc_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock, clk; reset rst is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 ena  in  1  fetch enable; 0 holds the block out of new requests.
REQ-005 pc_in  in  32  current PC from the upstream PC register.
REQ-006 npc  out  32  next PC to the PC register data input (combinational).
REQ-007 pc_ena  out  1  PC register load enable, one-cycle pulse (combinational).
REQ-008 redirect  in  1  branch/jump taken; flush and restart at redirect_pc.
REQ-009 redirect_pc  in  32  redirect target address.
REQ-010 imem_req  out  1  instruction memory request valid.
REQ-011 imem_addr  out  32  request address.
REQ-012 imem_gnt  in  1  memory accepts the request this cycle (imem_req && imem_gnt).
REQ-013 imem_rvalid  in  1  read data valid, at least one cycle after grant.
REQ-014 imem_rdata  in  32  read data.
REQ-015 inst_valid  out  1  registered; instruction available downstream.
REQ-016 inst_ready  in  1  downstream accepts instruction (inst_valid && inst_ready).
REQ-017 inst_out  out  32  registered instruction word.
REQ-018 inst_pc  out  32  registered address of inst_out.

Function
REQ-019 The block SHALL implement states IDLE, REQ, WAIT, HOLD with at most one outstanding memory request.
REQ-020 IDLE: imem_req=0; next state REQ when ena=1, else IDLE.
REQ-021 REQ: imem_req=1, imem_addr=pc_in; on imem_gnt capture pc_in into req_pc, pulse pc_ena, go WAIT; otherwise stay REQ with request and address held stable, regardless of ena.
REQ-022 WAIT: on imem_rvalid with kill=0, load inst_out=imem_rdata, inst_pc=req_pc, set inst_valid, go HOLD; with kill=1 discard data, clear kill, go REQ if ena=1 else IDLE.
REQ-023 HOLD: inst_valid=1, inst_out/inst_pc stable; on inst_ready clear inst_valid, go REQ if ena=1 else IDLE.
REQ-024 Sequential npc SHALL be pc_in+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-025 redirect=1 in any non-reset cycle SHALL pulse pc_ena with npc={redirect_pc[31:2],2'b00}; this takes priority over the sequential increment.
REQ-026 redirect in REQ with imem_gnt=1: the granted request SHALL be marked kill=1, state goes to WAIT.
REQ-027 redirect in REQ without grant: request continues at the new pc_in next cycle (address may change only because pc_in changed).
REQ-028 redirect in WAIT SHALL set kill=1; the in-flight response is discarded.
REQ-029 redirect in HOLD SHALL clear inst_valid next cycle, even if inst_ready=1 the same cycle, and go REQ.
REQ-030 redirect in IDLE SHALL only update the PC; state follows REQ-020.
REQ-031 imem_rvalid outside WAIT SHALL be ignored.
REQ-032 Minimum latency: grant in cycle N, rvalid in N+1 -> inst_valid high in N+2.

Reset
REQ-033 rst=0 at a posedge SHALL set state=IDLE, kill=0, inst_valid=0, inst_out=0, inst_pc=0, req_pc=0; imem_req and pc_ena are 0 while rst=0.
REQ-034 Reset mid-WAIT SHALL abandon the request; a late imem_rvalid after reset is ignored per REQ-031.

Verification
REQ-035 Basic: pc_in=0x00000000, ena=1, gnt same cycle, rvalid next cycle with 0x00500093 -> pc_ena pulse with npc=0x4; inst_valid with inst_out=0x00500093, inst_pc=0x0.
REQ-036 Backpressure: inst_ready=0 for 5 cycles -> inst_valid, inst_out, inst_pc stable, imem_req=0, no pc_ena.
REQ-037 Wrap: pc_in=0xFFFFFFFC granted -> npc=0x00000000.
REQ-038 Kill: redirect with redirect_pc=0x00000103 during WAIT -> npc=0x00000100, pc_ena pulse, returned data dropped (inst_valid stays 0), next request at 0x00000100.
REQ-039 Stall on grant: imem_gnt=0 for 3 cycles, ena dropped to 0 -> imem_req and imem_addr held until grant.
REQ-040 Reset in WAIT: rst=0 one cycle then rvalid=1 -> inst_valid stays 0, state IDLE.
